// File: rtl/cache_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and defaults for the cache/memory arbiter:
//               FSM state encoding, grant owner encoding, line geometry and
//               a saturating counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int C_LINE_W = 256;
    localparam int C_BUS_W  = 64;
    localparam int C_BEATS  = C_LINE_W / C_BUS_W;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR_BURST = 3'd3,
        RESP     = 3'd4
    } mem_arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } mem_arb_gnt_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter_if
// Description : Bundle of icache, dcache, memory-burst and status signals
//               around the arbiter. slave = arbiter side, master = the
//               environment (caches + memory).
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_mem_arbiter_if #(
    parameter int LINE_W = mem_arb_pkg::C_LINE_W,
    parameter int BUS_W  = mem_arb_pkg::C_BUS_W
) ();
    // icache
    logic [31:0]       i_addr;
    logic              i_read;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    // dcache
    logic [31:0]       d_addr;
    logic              d_read;
    logic              d_write;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    // memory burst port
    logic [31:0]       bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BUS_W-1:0]  bmem_wdata;
    logic              bmem_ready;
    logic [BUS_W-1:0]  bmem_rdata;
    logic              bmem_rvalid;
    // status
    logic [31:0]       i_grants;
    logic [31:0]       d_grants;
    logic              stray_beat;

    modport slave (
        input  i_addr, i_read, d_addr, d_read, d_write, d_wdata,
        input  bmem_ready, bmem_rdata, bmem_rvalid,
        output i_rdata, i_resp, d_rdata, d_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output i_grants, d_grants, stray_beat
    );

    modport master (
        output i_addr, i_read, d_addr, d_read, d_write, d_wdata,
        output bmem_ready, bmem_rdata, bmem_rvalid,
        input  i_rdata, i_resp, d_rdata, d_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  i_grants, d_grants, stray_beat
    );
endinterface
`default_nettype wire

// File: rtl/cache_mem_arbiter_line_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : line_deserializer
// Description : Collects BUS_W-wide memory beats into one LINE_W cache line.
//               o_line shows the stored line with the current beat already
//               merged in, so the final beat can be consumed in its own cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module line_deserializer #(
    parameter int LINE_W = mem_arb_pkg::C_LINE_W,
    parameter int BUS_W  = mem_arb_pkg::C_BUS_W,
    parameter int IDX_W  = $clog2(LINE_W / BUS_W)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_load,
    input  wire logic [IDX_W-1:0]  i_beat_idx,
    input  wire logic [BUS_W-1:0]  i_beat_data,
    output logic      [LINE_W-1:0] o_line
);

    logic [LINE_W-1:0] r_line;

    // Merge the incoming beat into its slice of the stored line.
    always_comb begin
        o_line = r_line;
        if (i_load) begin
            o_line[int'(i_beat_idx)*BUS_W +: BUS_W] = i_beat_data;
        end
    end

    // Commit loaded beats; reset clears any partially assembled line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_line <= '0;
        end else if (i_load) begin
            r_line <= o_line;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter
// Description : Round-robin arbiter sharing one burst memory port between an
//               icache (reads) and a dcache (reads/writes). Lines move as
//               BEATS beats of BUS_W bits; grant counters and a sticky
//               stray-beat flag are exported for status.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LINE_W = C_LINE_W,
    parameter int BUS_W  = C_BUS_W
) (
    input  wire logic           clk,
    input  wire logic           rst,
    cache_mem_arbiter_if.slave  bus
);

    localparam int          BEATS      = LINE_W / BUS_W;
    localparam int          CNT_W      = $clog2(BEATS);
    localparam logic [31:0] C_LINE_MSK = 32'hFFFF_FFE0;

    mem_arb_state_t    r_state;
    mem_arb_gnt_t      r_gnt;        // current owner, doubles as last grant
    logic [31:0]       r_addr;
    logic [LINE_W-1:0] r_wline;
    logic [CNT_W-1:0]  r_beat;
    logic              r_bmem_read;
    logic              r_bmem_write;
    logic [BUS_W-1:0]  r_bmem_wdata;
    logic [LINE_W-1:0] r_i_rdata;
    logic [LINE_W-1:0] r_d_rdata;
    logic              r_i_resp;
    logic              r_d_resp;
    logic [31:0]       r_i_grants;
    logic [31:0]       r_d_grants;
    logic              r_stray;

    logic              w_d_req;
    logic              w_any_req;
    mem_arb_gnt_t      w_gnt;
    logic              w_last_beat;
    logic              w_beat_load;
    logic [LINE_W-1:0] w_line;

    assign w_last_beat = (r_beat == CNT_W'(BEATS - 1));
    assign w_beat_load = (r_state == RD_WAIT) && bus.bmem_rvalid;

    // Pick the next owner: sole requester wins, a tie goes to whoever was not served last.
    always_comb begin
        w_d_req   = bus.d_read | bus.d_write;
        w_any_req = bus.i_read | w_d_req;
        w_gnt     = GNT_I;
        if (bus.i_read && w_d_req) begin
            w_gnt = (r_gnt == GNT_I) ? GNT_D : GNT_I;
        end else if (w_d_req) begin
            w_gnt = GNT_D;
        end
    end

    line_deserializer #(
        .LINE_W (LINE_W),
        .BUS_W  (BUS_W),
        .IDX_W  (CNT_W)
    ) u_deser (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_beat_load),
        .i_beat_idx  (r_beat),
        .i_beat_data (bus.bmem_rdata),
        .o_line      (w_line)
    );

    // Arbitration / burst sequencing FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_gnt        <= GNT_I;
            r_addr       <= '0;
            r_wline      <= '0;
            r_beat       <= '0;
            r_bmem_read  <= 1'b0;
            r_bmem_write <= 1'b0;
            r_bmem_wdata <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_i_resp     <= 1'b0;
            r_d_resp     <= 1'b0;
            r_i_grants   <= '0;
            r_d_grants   <= '0;
            r_stray      <= 1'b0;
        end else begin
            r_i_resp <= 1'b0;
            r_d_resp <= 1'b0;
            // A beat with no read burst to land in is dropped but remembered.
            if (bus.bmem_rvalid && (r_state != RD_WAIT)) begin
                r_stray <= 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_gnt  <= w_gnt;
                        r_beat <= '0;
                        if (w_gnt == GNT_I) begin
                            r_addr      <= bus.i_addr & C_LINE_MSK;
                            r_i_grants  <= sat_inc32(r_i_grants);
                            r_bmem_read <= 1'b1;
                            r_state     <= RD_ISSUE;
                        end else begin
                            r_addr     <= bus.d_addr & C_LINE_MSK;
                            r_wline    <= bus.d_wdata;
                            r_d_grants <= sat_inc32(r_d_grants);
                            // Write wins when both read and write are raised.
                            if (bus.d_write) begin
                                r_bmem_write <= 1'b1;
                                r_bmem_wdata <= bus.d_wdata[BUS_W-1:0];
                                r_state      <= WR_BURST;
                            end else begin
                                r_bmem_read <= 1'b1;
                                r_state     <= RD_ISSUE;
                            end
                        end
                    end
                end
                RD_ISSUE: begin
                    if (bus.bmem_ready) begin
                        r_bmem_read <= 1'b0;
                        r_state     <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (bus.bmem_rvalid) begin
                        r_beat <= r_beat + CNT_W'(1);
                        if (w_last_beat) begin
                            r_state <= RESP;
                            if (r_gnt == GNT_I) begin
                                r_i_resp  <= 1'b1;
                                r_i_rdata <= w_line;
                            end else begin
                                r_d_resp  <= 1'b1;
                                r_d_rdata <= w_line;
                            end
                        end
                    end
                end
                WR_BURST: begin
                    if (bus.bmem_ready) begin
                        r_beat <= r_beat + CNT_W'(1);
                        if (w_last_beat) begin
                            r_bmem_write <= 1'b0;
                            r_d_resp     <= 1'b1;
                            r_state      <= RESP;
                        end else begin
                            r_bmem_wdata <= r_wline[(int'(r_beat) + 1)*BUS_W +: BUS_W];
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.bmem_addr  = r_addr;
    assign bus.bmem_read  = r_bmem_read;
    assign bus.bmem_write = r_bmem_write;
    assign bus.bmem_wdata = r_bmem_wdata;
    assign bus.i_rdata    = r_i_rdata;
    assign bus.i_resp     = r_i_resp;
    assign bus.d_rdata    = r_d_rdata;
    assign bus.d_resp     = r_d_resp;
    assign bus.i_grants   = r_i_grants;
    assign bus.d_grants   = r_d_grants;
    assign bus.stray_beat = r_stray;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_cache_mem_arbiter
// Description : Directed self-checking bench for cache_mem_arbiter. Inputs
//               change on the falling edge, outputs are sampled there too.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_mem_arbiter_if bus ();

    cache_mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [255:0] C_L1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] C_L2 = {64'hA0A1_A2A3_A4A5_A6A7, 64'hB0B1_B2B3_B4B5_B6B7,
                                     64'hC0C1_C2C3_C4C5_C6C7, 64'hD0D1_D2D3_D4D5_D6D7};
    localparam logic [255:0] C_L3 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                     64'hDEAD_BEEF_CAFE_F00D, 64'h1357_9BDF_2468_ACE0};
    localparam logic [255:0] C_L4 = {64'h5555_0000_5555_0000, 64'h0000_AAAA_0000_AAAA,
                                     64'h1234_0000_0000_4321, 64'h8000_0000_0000_0001};

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.i_addr      = '0;
        bus.i_read      = 1'b0;
        bus.d_addr      = '0;
        bus.d_read      = 1'b0;
        bus.d_write     = 1'b0;
        bus.d_wdata     = '0;
        bus.bmem_ready  = 1'b0;
        bus.bmem_rdata  = '0;
        bus.bmem_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait (bounded) for the arbiter to start a read (wr=0) or write (wr=1) burst.
    task automatic wait_burst(input string tag, input bit wr);
        int t = 0;
        while (((wr ? bus.bmem_write : bus.bmem_read) !== 1'b1) && (t < 20)) begin
            @(negedge clk);
            t++;
        end
        chk(tag, wr ? bus.bmem_write : bus.bmem_read, 1);
    endtask

    // Play the memory for one read: one stalled issue cycle, accept, then four beats.
    task automatic serve_read(input string tag, input logic [255:0] line, input logic [31:0] exp_addr);
        wait_burst({tag, " start"}, 1'b0);
        chk({tag, " addr"}, bus.bmem_addr, exp_addr);
        chk({tag, " no write"}, bus.bmem_write, 0);
        @(negedge clk);
        chk({tag, " issue held"}, bus.bmem_read, 1);
        bus.bmem_ready = 1'b1;
        @(negedge clk);
        bus.bmem_ready = 1'b0;
        chk({tag, " issue dropped"}, bus.bmem_read, 0);
        for (int b = 0; b < 4; b++) begin
            bus.bmem_rvalid = 1'b1;
            bus.bmem_rdata  = line[b*64 +: 64];
            @(negedge clk);
        end
        bus.bmem_rvalid = 1'b0;
        bus.bmem_rdata  = '0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] pat;
        int         nb;

        // ---------------- reset state ----------------
        do_reset();
        chk("rst i_grants", bus.i_grants, 0);
        chk("rst d_grants", bus.d_grants, 0);
        chk("rst stray", bus.stray_beat, 0);
        chk("rst i_rdata", bus.i_rdata, 0);
        chk("rst d_rdata", bus.d_rdata, 0);
        chk("rst resp", {bus.i_resp, bus.d_resp}, 0);
        chk("rst bmem rw", {bus.bmem_read, bus.bmem_write}, 0);
        chk("rst bmem_addr", bus.bmem_addr, 0);

        // ---------------- icache only ----------------
        bus.i_addr = 32'h0000_1234;
        bus.i_read = 1'b1;
        serve_read("t1", C_L1, 32'h0000_1220);
        chk("t1 i_resp", bus.i_resp, 1);
        chk("t1 d_resp", bus.d_resp, 0);
        chk("t1 i_rdata", bus.i_rdata, C_L1);
        chk("t1 i_grants", bus.i_grants, 1);
        bus.i_read = 1'b0;
        @(negedge clk);
        chk("t1 resp pulse", bus.i_resp, 0);
        chk("t1 rdata hold", bus.i_rdata, C_L1);

        // ---------------- contention, round robin ----------------
        do_reset();
        bus.i_addr = 32'h0000_2044;
        bus.d_addr = 32'h0000_307F;
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        serve_read("t2 d1", C_L2, 32'h0000_3060);
        chk("t2 d1 d_resp", bus.d_resp, 1);
        chk("t2 d1 i_resp", bus.i_resp, 0);
        chk("t2 d1 d_rdata", bus.d_rdata, C_L2);
        bus.d_read = 1'b0;
        @(negedge clk);
        chk("t2 bubble", bus.bmem_read, 0);
        serve_read("t2 i1", C_L3, 32'h0000_2040);
        chk("t2 i1 i_resp", bus.i_resp, 1);
        chk("t2 i1 i_rdata", bus.i_rdata, C_L3);
        chk("t2 d_rdata hold", bus.d_rdata, C_L2);
        bus.i_read = 1'b0;
        @(negedge clk);
        bus.i_addr = 32'h0000_8000;
        bus.d_addr = 32'h0000_9021;
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        serve_read("t2 d2", C_L4, 32'h0000_9020);
        chk("t2 d2 d_resp", bus.d_resp, 1);
        chk("t2 d2 d_rdata", bus.d_rdata, C_L4);
        bus.d_read = 1'b0;
        serve_read("t2 i2", C_L1, 32'h0000_8000);
        chk("t2 i2 i_resp", bus.i_resp, 1);
        chk("t2 i2 i_rdata", bus.i_rdata, C_L1);
        bus.i_read = 1'b0;
        chk("t2 i_grants", bus.i_grants, 2);
        chk("t2 d_grants", bus.d_grants, 2);
        @(negedge clk);

        // ---------------- dcache write with ready stalls ----------------
        do_reset();
        bus.d_addr  = 32'h0000_4000;
        bus.d_wdata = C_L1;
        bus.d_write = 1'b1;
        wait_burst("t3 start", 1'b1);
        chk("t3 addr", bus.bmem_addr, 32'h0000_4000);
        pat = 6'b101101;   // ready sequence 1,0,1,1,0,1 from bit 0 upward
        nb  = 0;
        for (int k = 0; k < 6; k++) begin
            bus.bmem_ready = pat[k];
            chk($sformatf("t3 write k%0d", k), bus.bmem_write, 1);
            chk($sformatf("t3 no read k%0d", k), bus.bmem_read, 0);
            chk($sformatf("t3 wdata k%0d", k), bus.bmem_wdata, C_L1[nb*64 +: 64]);
            if (pat[k]) nb++;
            @(negedge clk);
        end
        bus.bmem_ready = 1'b0;
        chk("t3 d_resp", bus.d_resp, 1);
        chk("t3 write done", bus.bmem_write, 0);
        chk("t3 d_grants", bus.d_grants, 1);
        bus.d_write = 1'b0;
        @(negedge clk);
        chk("t3 resp pulse", bus.d_resp, 0);

        // ---------------- reset mid read burst ----------------
        do_reset();
        bus.i_addr = 32'h0000_5010;
        bus.i_read = 1'b1;
        wait_burst("t4 start", 1'b0);
        bus.bmem_ready = 1'b1;
        @(negedge clk);
        bus.bmem_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus.bmem_rvalid = 1'b1;
            bus.bmem_rdata  = C_L2[b*64 +: 64];
            @(negedge clk);
        end
        rst = 1'b1;
        bus.bmem_rvalid = 1'b0;
        bus.i_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("t4 rst stray", bus.stray_beat, 0);
        chk("t4 rst i_grants", bus.i_grants, 0);
        for (int b = 2; b < 4; b++) begin
            bus.bmem_rvalid = 1'b1;
            bus.bmem_rdata  = C_L2[b*64 +: 64];
            @(negedge clk);
            chk($sformatf("t4 no resp b%0d", b), bus.i_resp, 0);
        end
        bus.bmem_rvalid = 1'b0;
        chk("t4 stray set", bus.stray_beat, 1);
        chk("t4 i_rdata clear", bus.i_rdata, 0);
        chk("t4 idle no read", bus.bmem_read, 0);
        bus.i_addr = 32'h0000_6000;
        bus.i_read = 1'b1;
        serve_read("t4 next", C_L3, 32'h0000_6000);
        chk("t4 next i_resp", bus.i_resp, 1);
        chk("t4 next i_rdata", bus.i_rdata, C_L3);
        chk("t4 stray sticky", bus.stray_beat, 1);
        bus.i_read = 1'b0;
        @(negedge clk);

        // ---------------- read+write together -> write ----------------
        bus.d_addr  = 32'h0000_7008;
        bus.d_wdata = C_L4;
        bus.d_read  = 1'b1;
        bus.d_write = 1'b1;
        wait_burst("t5 start", 1'b1);
        chk("t5 addr", bus.bmem_addr, 32'h0000_7000);
        for (int b = 0; b < 4; b++) begin
            bus.bmem_ready = 1'b1;
            chk($sformatf("t5 no read b%0d", b), bus.bmem_read, 0);
            chk($sformatf("t5 wdata b%0d", b), bus.bmem_wdata, C_L4[b*64 +: 64]);
            @(negedge clk);
        end
        bus.bmem_ready = 1'b0;
        chk("t5 d_resp", bus.d_resp, 1);
        chk("t5 no read end", bus.bmem_read, 0);
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        @(negedge clk);

        // ---------------- grant counter saturation ----------------
        force dut.r_i_grants = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.r_i_grants;
        @(negedge clk);
        chk("t6 preload", bus.i_grants, 32'hFFFF_FFFE);
        for (int n = 0; n < 3; n++) begin
            bus.i_addr = 32'h0000_A000 + 32'(n * 32);
            bus.i_read = 1'b1;
            serve_read($sformatf("t6 r%0d", n), C_L2, 32'h0000_A000 + 32'(n * 32));
            chk($sformatf("t6 resp%0d", n), bus.i_resp, 1);
            chk($sformatf("t6 sat%0d", n), bus.i_grants, 32'hFFFF_FFFF);
            bus.i_read = 1'b0;
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
